barrett_mod_mul: RTL

- Pipelined modular multiplier: r = (a * b) mod q, using Barrett reduction.
- Sits directly downstream of the precomputed-constant table. It consumes the modulus q and the Barrett factor mu = floor(2^53 / q), which the table exposes as its Pre_computing output.
- Feeds the radix-3/5/7 butterfly datapath, which multiplies by the table's Cxy twiddles and inv_n scalars.
- Fully pipelined: one result per cycle, with valid/ready backpressure.

---
 rtl/barrett_mod_mul_if.sv | 26 ++
 rtl/barrett_mod_mul.sv | 93 +++++++++
 2 files changed

// File: rtl/barrett_mod_mul_if.sv
// Operand/result handshake bundle for barrett_mod_mul.
// The master side feeds operands and accepts results.
interface barrett_mod_mul_if #(
    parameter int unsigned DATA_W = 26,
    parameter int unsigned TAG_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;

    modport master (
        output in_valid, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/barrett_mod_mul.sv
// Four-stage pipelined modular multiplier: out = (a * b) mod q.
// Uses Barrett reduction with a precomputed mu = floor(2^53 / q).
module barrett_mod_mul #(
    parameter int unsigned DATA_W  = 26,
    parameter int unsigned MU_W    = 28,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned SHIFT_A = 25,
    parameter int unsigned SHIFT_B = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] mod_q,
    input  logic [MU_W-1:0]   mu,
    barrett_mod_mul_if.slave  bus
);
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned XS_W   = PROD_W - SHIFT_A;
    localparam int unsigned T_W    = XS_W + MU_W;
    localparam int unsigned QE_W   = T_W - SHIFT_B;
    localparam int unsigned R_W    = DATA_W + 2;

    logic              adv;
    logic              v1;
    logic              v2;
    logic              v3;
    logic [PROD_W-1:0] x1;
    logic [R_W-1:0]    x2;
    logic [QE_W-1:0]   qe2;
    logic [R_W-1:0]    r3;
    logic [TAG_W-1:0]  tag1;
    logic [TAG_W-1:0]  tag2;
    logic [TAG_W-1:0]  tag3;

    logic [PROD_W-1:0] prod_c;
    logic [QE_W-1:0]   qe_c;
    logic [R_W-1:0]    r0_c;
    logic [R_W-1:0]    q1_c;
    logic [R_W-1:0]    q2_c;
    logic [DATA_W-1:0] res_c;

    // Whole pipe advances together; a full output register with no taker freezes it.
    assign adv          = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = adv;

    // Stage datapaths. Only the low R_W bits of x and q_est*q matter since r0 < 3q < 2^R_W.
    always_comb begin
        prod_c = PROD_W'(bus.in_a) * PROD_W'(bus.in_b);
        qe_c   = QE_W'((T_W'(x1[PROD_W-1:SHIFT_A]) * T_W'(mu)) >> SHIFT_B);
        r0_c   = x2 - R_W'(R_W'(qe2) * R_W'(mod_q));
        q1_c   = R_W'(mod_q);
        q2_c   = R_W'(mod_q) << 1;
        if (r3 >= q2_c) begin
            res_c = DATA_W'(r3 - q2_c);
        end else if (r3 >= q1_c) begin
            res_c = DATA_W'(r3 - q1_c);
        end else begin
            res_c = DATA_W'(r3);
        end
    end

    // Stage registers; bubbles shift exactly like valid data.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1            <= 1'b0;
            v2            <= 1'b0;
            v3            <= 1'b0;
            x1            <= '0;
            x2            <= '0;
            qe2           <= '0;
            r3            <= '0;
            tag1          <= '0;
            tag2          <= '0;
            tag3          <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_tag   <= '0;
        end else if (adv) begin
            v1            <= bus.in_valid & adv;
            x1            <= prod_c;
            tag1          <= bus.in_tag;
            v2            <= v1;
            x2            <= x1[R_W-1:0];
            qe2           <= qe_c;
            tag2          <= tag1;
            v3            <= v2;
            r3            <= r0_c;
            tag3          <= tag2;
            bus.out_valid <= v3;
            bus.out_data  <= res_c;
            bus.out_tag   <= tag3;
        end
    end
endmodule
